// File: rtl/chip_ctrl_driver_pkg.sv
// Shared encodings for the chip control-pad driver: command ops, FSM states
// and the peristaltic pump step table.
package chip_ctrl_driver_pkg;

   typedef enum logic [1:0] {
      OpSet   = 2'd0,
      OpPump  = 2'd1,
      OpFlush = 2'd2,
      OpRsvd  = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StSettle = 2'd1,
      StPump   = 2'd2,
      StFlush  = 2'd3
   } state_e;

   localparam int unsigned NumPumpSteps = 6;

   // All three pump pads pressurized: pump sealed at rest
   localparam logic [2:0] PumpRest = 3'b111;

   // Entry [0] is S0; forward walks upward, reverse walks downward
   localparam logic [NumPumpSteps-1:0][2:0] PumpSteps = {
      3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101
   };

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/chip_pump_stepper.sv
// Pump step sequencer: holds the step-table index and direction and offers
// the pattern of the neighbouring step so the owner can register it.
module chip_pump_stepper
   import chip_ctrl_driver_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       dir_i,
   input  logic       step_i,
   output logic [2:0] next_pat_o
);

   logic [2:0] idx_q, idx_d, idx_adv;
   logic       dir_q, dir_d;

   // Neighbour index in the current direction, wrapping at both table ends
   always_comb begin
      if (dir_q) begin
         idx_adv = (idx_q == 3'd0) ? 3'(NumPumpSteps - 1) : idx_q - 3'd1;
      end else begin
         idx_adv = (idx_q == 3'(NumPumpSteps - 1)) ? 3'd0 : idx_q + 3'd1;
      end
   end

   // Start rewinds to S0 and latches direction; step moves to the neighbour
   always_comb begin
      idx_d = idx_q;
      dir_d = dir_q;
      if (start_i) begin
         idx_d = 3'd0;
         dir_d = dir_i;
      end else if (step_i) begin
         idx_d = idx_adv;
      end
   end

   assign next_pat_o = PumpSteps[idx_adv];

   // Index and direction registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= 3'd0;
         dir_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         dir_q <= dir_d;
      end
   end

endmodule

// File: rtl/chip_ctrl_driver.sv
// Chip control-pad driver: accepts SET / PUMP / FLUSH commands and sequences
// the valve, pump and flush-vent pads with settle, step and vent hold timing.
module chip_ctrl_driver
   import chip_ctrl_driver_pkg::*;
#(
   parameter int unsigned NUM_VALVES    = 19,
   parameter int unsigned PHASE_CYCLES  = 1000,
   parameter int unsigned SETTLE_CYCLES = 100,
   parameter int unsigned FLUSH_CYCLES  = 500
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [NUM_VALVES-1:0] cmd_mask,
   input  logic [NUM_VALVES-1:0] cmd_data,
   input  logic [15:0]           cmd_count,
   input  logic                  abort,
   output logic [NUM_VALVES-1:0] ctrl_out,
   output logic [2:0]            pump_out,
   output logic [NUM_VALVES-1:0] flush_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned CntW =
      $clog2(max3(PHASE_CYCLES, SETTLE_CYCLES, FLUSH_CYCLES) + 1);

   state_e                state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [2:0]            step_q, step_d;
   logic [15:0]           cyc_q, cyc_d;
   logic [15:0]           count_q, count_d;
   logic [NUM_VALVES-1:0] ctrl_q, ctrl_d;
   logic [2:0]            pump_q, pump_d;
   logic [NUM_VALVES-1:0] flush_q, flush_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic       st_start, st_step;
   logic [2:0] st_next_pat;

   chip_pump_stepper u_stepper (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (st_start),
      .dir_i      (cmd_data[0]),
      .step_i     (st_step),
      .next_pat_o (st_next_pat)
   );

   // Command acceptance, hold timing and completion; abort overrides all
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      step_d   = step_q;
      cyc_d    = cyc_q;
      count_d  = count_q;
      ctrl_d   = ctrl_q;
      pump_d   = pump_q;
      flush_d  = flush_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      st_start = 1'b0;
      st_step  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               unique case (cmd_op_e'(cmd_op))
                  OpSet: begin
                     ctrl_d  = (ctrl_q & ~cmd_mask) | (cmd_data & cmd_mask);
                     cnt_d   = '0;
                     state_d = StSettle;
                  end
                  OpPump: begin
                     if (cmd_count == 16'd0) begin
                        done_d = 1'b1;
                     end else begin
                        st_start = 1'b1;
                        pump_d   = PumpSteps[0];
                        cnt_d    = '0;
                        step_d   = 3'd0;
                        cyc_d    = 16'd0;
                        count_d  = cmd_count;
                        state_d  = StPump;
                     end
                  end
                  OpFlush: begin
                     flush_d = cmd_mask;
                     ctrl_d  = ctrl_q & ~cmd_mask;
                     cnt_d   = '0;
                     state_d = StFlush;
                  end
                  default: begin
                     done_d = 1'b1;
                     err_d  = 1'b1;
                  end
               endcase
            end
         end

         StSettle: begin
            if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StPump: begin
            if (cnt_q == CntW'(PHASE_CYCLES - 1)) begin
               cnt_d = '0;
               if (step_q == 3'(NumPumpSteps - 1)) begin
                  step_d = 3'd0;
                  // count_q is never zero here, so count_q - 1 cannot wrap
                  if (cyc_q == count_q - 16'd1) begin
                     pump_d  = PumpRest;
                     done_d  = 1'b1;
                     state_d = StIdle;
                  end else begin
                     cyc_d   = cyc_q + 16'd1;
                     st_step = 1'b1;
                     pump_d  = st_next_pat;
                  end
               end else begin
                  step_d  = step_q + 3'd1;
                  st_step = 1'b1;
                  pump_d  = st_next_pat;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         StFlush: begin
            if (cnt_q == CntW'(FLUSH_CYCLES - 1)) begin
               flush_d = '0;
               done_d  = 1'b1;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: state_d = StIdle;
      endcase

      // Abort only applies to a running command; valve state is kept as-is
      if (abort && (state_q != StIdle)) begin
         state_d = StIdle;
         ctrl_d  = ctrl_q;
         pump_d  = PumpRest;
         flush_d = '0;
         cnt_d   = '0;
         step_d  = 3'd0;
         cyc_d   = 16'd0;
         st_step = 1'b0;
         done_d  = 1'b1;
         err_d   = 1'b0;
      end
   end

   // State, counters and registered pad outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         step_q  <= 3'd0;
         cyc_q   <= 16'd0;
         count_q <= 16'd0;
         ctrl_q  <= '0;
         pump_q  <= PumpRest;
         flush_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         step_q  <= step_d;
         cyc_q   <= cyc_d;
         count_q <= count_d;
         ctrl_q  <= ctrl_d;
         pump_q  <= pump_d;
         flush_q <= flush_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready = (state_q == StIdle);
   assign busy      = ~cmd_ready;
   assign ctrl_out  = ctrl_q;
   assign pump_out  = pump_q;
   assign flush_out = flush_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_chip_ctrl_driver.sv
// Randomized bench for chip_ctrl_driver against a timeline model of each command.
module tb_chip_ctrl_driver;

   localparam int NV     = 19;
   localparam int PHASE  = 4;
   localparam int SETTLE = 3;
   localparam int FLUSH  = 5;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [NV-1:0] cmd_mask;
   logic [NV-1:0] cmd_data;
   logic [15:0]   cmd_count;
   logic          abort;
   logic [NV-1:0] ctrl_out;
   logic [2:0]    pump_out;
   logic [NV-1:0] flush_out;
   logic          busy;
   logic          done;
   logic          err;

   int n_cmp = 0;
   int n_err = 0;

   logic [NV-1:0] exp_ctrl;

   chip_ctrl_driver #(
      .NUM_VALVES    (NV),
      .PHASE_CYCLES  (PHASE),
      .SETTLE_CYCLES (SETTLE),
      .FLUSH_CYCLES  (FLUSH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_mask  (cmd_mask),
      .cmd_data  (cmd_data),
      .cmd_count (cmd_count),
      .abort     (abort),
      .ctrl_out  (ctrl_out),
      .pump_out  (pump_out),
      .flush_out (flush_out),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected pump pattern c cycles into a pump run
   function automatic logic [2:0] exp_pump(input int c, input bit rev);
      logic [2:0] tbl [6];
      int pos;
      tbl = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
      pos = (c / PHASE) % 6;
      if (rev) pos = (6 - pos) % 6;
      return tbl[pos];
   endfunction

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_ctrl"}, 32'(ctrl_out), 32'(exp_ctrl));
      check_eq({tag, "_pump"}, 32'(pump_out), 32'h7);
      check_eq({tag, "_flush"}, 32'(flush_out), 32'd0);
   endtask

   // Issue one command, then check every cycle until one cycle after done.
   // abort_at = k > 0 raises abort right after the k-th post-accept sample.
   task automatic do_cmd(input int op, input logic [NV-1:0] mask, input logic [NV-1:0] data,
                         input int count, input int abort_at, input bit abort_on_accept);
      int len;
      int end_k;
      bit busy_e;
      logic [2:0] pump_e;
      logic [NV-1:0] flush_e;
      case (op)
         0:       len = SETTLE;
         1:       len = 6 * count * PHASE;
         2:       len = FLUSH;
         default: len = 0;
      endcase
      if (abort_at > len) abort_at = 0;
      @(negedge clk);
      check_eq("ready_pre", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = 2'(op);
      cmd_mask  = mask;
      cmd_data  = data;
      cmd_count = 16'(count);
      abort     = abort_on_accept;
      @(negedge clk);
      cmd_valid = 1'b0;
      abort     = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_mask  = NV'($urandom);
      cmd_data  = NV'($urandom);
      cmd_count = 16'($urandom);
      if (op == 0) exp_ctrl = (exp_ctrl & ~mask) | (data & mask);
      if (op == 2) exp_ctrl = exp_ctrl & ~mask;
      end_k = (abort_at > 0) ? abort_at + 1 : len + 1;
      for (int k = 1; k <= end_k + 1; k++) begin
         if (k > 1) @(negedge clk);
         busy_e  = (k < end_k);
         pump_e  = (op == 1 && busy_e) ? exp_pump(k - 1, data[0]) : 3'b111;
         flush_e = (op == 2 && busy_e) ? mask : '0;
         check_eq("busy", 32'(busy), 32'(busy_e));
         check_eq("ready", 32'(cmd_ready), 32'(!busy_e));
         check_eq("done", 32'(done), 32'(k == end_k));
         check_eq("err", 32'(err), 32'(op == 3 && k == 1));
         check_eq("ctrl", 32'(ctrl_out), 32'(exp_ctrl));
         check_eq("pump", 32'(pump_out), 32'(pump_e));
         check_eq("flush", 32'(flush_out), 32'(flush_e));
         abort = (k == abort_at);
      end
      abort = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = 2'd0;
      cmd_mask  = '0;
      cmd_data  = '0;
      cmd_count = 16'd0;
      abort     = 1'b0;
      exp_ctrl  = '0;

      #12;
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_idle_outputs("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // SET from reset, then pump forward x2, reverse x1, count zero
      do_cmd(0, 19'h00003, 19'h00001, 0, 0, 1'b0);
      check_eq("set_ctrl_const", 32'(ctrl_out), 32'h00001);
      do_cmd(1, '0, 19'h0, 2, 0, 1'b0);
      do_cmd(1, '0, 19'h1, 1, 0, 1'b0);
      do_cmd(1, '0, 19'h0, 0, 0, 1'b0);

      // Flush two lines out of an all-closed valve bank
      do_cmd(0, 19'h7FFFF, 19'h7FFFF, 0, 0, 1'b0);
      do_cmd(2, 19'h00030, 19'h12345, 0, 0, 1'b0);
      check_eq("flush_ctrl_const", 32'(ctrl_out), 32'h7FFCF);

      // Abort mid-pump, reserved op, abort coinciding with acceptance
      do_cmd(1, '0, 19'h0, 3, 6, 1'b0);
      do_cmd(3, 19'h7FFFF, 19'h00000, 0, 0, 1'b0);
      do_cmd(0, 19'h00F00, 19'h00A00, 0, 0, 1'b1);

      // Abort in idle must be ignored
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_idle_outputs("idle_abort");

      // Randomized command mix with occasional aborts and idle gaps
      for (int n = 0; n < 40; n++) begin
         int op;
         int cnt;
         int ab;
         op  = int'($urandom_range(0, 3));
         cnt = int'($urandom_range(0, 3));
         ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0;
         do_cmd(op, NV'($urandom), NV'($urandom), cnt, ab, 1'($urandom));
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            abort = 1'($urandom);
            cmd_op = 2'($urandom);
         end
         abort = 1'b0;
      end

      // Reset in the middle of a flush drops the command without done
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'd2;
      cmd_mask  = 19'h00005;
      @(negedge clk);
      cmd_valid = 1'b0;
      check_eq("mid_flush", 32'(flush_out), 32'h00005);
      @(negedge clk);
      rst_n = 1'b0;
      exp_ctrl = '0;
      #1;
      check_idle_outputs("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (FLUSH + 2) begin
         @(negedge clk);
         check_eq("post_rst_done", 32'(done), 32'd0);
      end
      check_idle_outputs("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
